// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller wrapped around an external 8-bit ALU.
// Ports: instr_* accept handshake, A/B/ALU_Sel to ALU, ALU_Out/CarryOut/Zero
// back, res_* result handshake, dbg_addr/dbg_data register-file peek.
module alu_issue_ctrl #(
  parameter int REG_AW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [REG_AW-1:0] instr_rd,
  input  logic [REG_AW-1:0] instr_rs1,
  input  logic [REG_AW-1:0] instr_rs2,
  input  logic              instr_use_imm,
  input  logic [7:0]        instr_imm,
  output logic [7:0]        A,
  output logic [7:0]        B,
  output logic [2:0]        ALU_Sel,
  input  logic [7:0]        ALU_Out,
  input  logic              CarryOut,
  input  logic              Zero,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [7:0]        res_data,
  output logic [REG_AW-1:0] res_rd,
  output logic              res_carry,
  output logic              res_zero,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [7:0]        dbg_data
);

  localparam int NREG = 2 ** REG_AW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        rf_q [NREG];
  logic [REG_AW-1:0] rd_q;
  logic [7:0]        a_q, b_q;
  logic [2:0]        sel_q;
  logic              rv_q;
  logic [7:0]        rdata_q;
  logic [REG_AW-1:0] rrd_q;
  logic              rcarry_q, rzero_q;

  logic              accept, capture, drain;
  logic [7:0]        b_d;

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    accept      = 1'b0;
    capture     = 1'b0;
    drain       = 1'b0;
    unique case (state_q)
      IDLE: begin
        instr_ready = !rst;
        if (instr_valid) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        capture = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (res_ready) begin
          drain   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // r0 is never written, so reading rf_q[0] already yields zero
  assign b_d = instr_use_imm ? instr_imm : rf_q[instr_rs2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      rd_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= '0;
      rv_q     <= 1'b0;
      rdata_q  <= '0;
      rrd_q    <= '0;
      rcarry_q <= 1'b0;
      rzero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q   <= rf_q[instr_rs1];
        b_q   <= b_d;
        sel_q <= instr_op;
        rd_q  <= instr_rd;
      end
      if (capture) begin
        rv_q     <= 1'b1;
        rdata_q  <= ALU_Out;
        rrd_q    <= rd_q;
        rcarry_q <= CarryOut;
        rzero_q  <= Zero;
        if (rd_q != '0) rf_q[rd_q] <= ALU_Out;
      end
      if (drain) rv_q <= 1'b0;
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign ALU_Sel   = sel_q;
  assign res_valid = rv_q;
  assign res_data  = rdata_q;
  assign res_rd    = rrd_q;
  assign res_carry = rcarry_q;
  assign res_zero  = rzero_q;
  assign dbg_data  = (dbg_addr == '0) ? 8'h00 : rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: ALU stand-in, transaction model,
// directed scenarios followed by randomized traffic.
module tb_alu_issue_ctrl;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          instr_valid, instr_ready;
  logic [2:0]    instr_op;
  logic [AW-1:0] instr_rd, instr_rs1, instr_rs2;
  logic          instr_use_imm;
  logic [7:0]    instr_imm;
  logic [7:0]    A, B;
  logic [2:0]    ALU_Sel;
  logic [7:0]    ALU_Out;
  logic          CarryOut, Zero;
  logic          res_valid, res_ready;
  logic [7:0]    res_data;
  logic [AW-1:0] res_rd;
  logic          res_carry, res_zero;
  logic [AW-1:0] dbg_addr;
  logic [7:0]    dbg_data;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.REG_AW(AW)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd),
    .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
    .instr_use_imm(instr_use_imm), .instr_imm(instr_imm),
    .A(A), .B(B), .ALU_Sel(ALU_Sel),
    .ALU_Out(ALU_Out), .CarryOut(CarryOut), .Zero(Zero),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_rd(res_rd),
    .res_carry(res_carry), .res_zero(res_zero),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  function automatic logic [8:0] alu(input logic [7:0] a, input logic [7:0] b,
                                     input logic [2:0] s);
    case (s)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a - b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return (a < b) ? 9'h001 : 9'h000;
      3'd6:    return {1'b0, a >> 1};
      default: return 9'h000;
    endcase
  endfunction

  always_comb begin
    {CarryOut, ALU_Out} = alu(A, B, ALU_Sel);
    Zero = (ALU_Out == 8'h00);
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, got, exp);
    end
  endtask

  // Transaction model: busy from accept until the result is consumed.
  logic [7:0] m_rf [4];
  int         m_phase;
  logic [7:0] m_a, m_b, m_data;
  logic [2:0] m_sel;
  logic [1:0] m_rd, m_rrd;
  logic       m_rv, m_carry, m_zero, m_on;
  logic [8:0] m_r;
  int         cyc;
  int         acc_q[$];

  initial m_on = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      foreach (m_rf[i]) m_rf[i] = 8'h00;
      m_phase = 0;
      m_a = 0; m_b = 0; m_sel = 0; m_rd = 0;
      m_rv = 0; m_data = 0; m_rrd = 0; m_carry = 0; m_zero = 0;
      m_on = 1'b1;
    end else if (m_on) begin
      if (m_phase == 0 && instr_valid) begin
        m_a   = m_rf[instr_rs1];
        m_b   = instr_use_imm ? instr_imm : m_rf[instr_rs2];
        m_sel = instr_op;
        m_rd  = instr_rd;
        m_phase = 1;
        acc_q.push_back(cyc);
      end else if (m_phase == 1) begin
        m_r     = alu(m_a, m_b, m_sel);
        m_data  = m_r[7:0];
        m_carry = m_r[8];
        m_zero  = (m_r[7:0] == 8'h00);
        m_rrd   = m_rd;
        if (m_rd != 0) m_rf[m_rd] = m_r[7:0];
        m_rv = 1'b1;
        m_phase = 2;
      end else if (m_phase == 2 && res_ready) begin
        m_rv = 1'b0;
        m_phase = 0;
      end
    end
    #1;
    if (m_on) begin
      chk("instr_ready", int'(instr_ready), int'(!rst && m_phase == 0));
      chk("res_valid", int'(res_valid), int'(m_rv));
      chk("res_data", int'(res_data), int'(m_data));
      chk("res_rd", int'(res_rd), int'(m_rrd));
      chk("res_carry", int'(res_carry), int'(m_carry));
      chk("res_zero", int'(res_zero), int'(m_zero));
      chk("A", int'(A), int'(m_a));
      chk("B", int'(B), int'(m_b));
      chk("ALU_Sel", int'(ALU_Sel), int'(m_sel));
      chk("dbg_data", int'(dbg_data), int'(m_rf[dbg_addr]));
    end
  end

  task automatic issue(input logic [2:0] op, input logic [1:0] rd,
                       input logic [1:0] rs1, input logic [1:0] rs2,
                       input logic ui, input logic [7:0] imm,
                       output logic [7:0] ga, output logic [7:0] gb,
                       output logic [7:0] gd, output logic [1:0] gr,
                       output logic gc, output logic gz);
    int n;
    instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
    instr_use_imm = ui; instr_imm = imm; instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 20) begin @(negedge clk); n++; end
    chk("accept_wait", int'(n < 20), 1);
    @(negedge clk);
    instr_valid = 1'b0;
    ga = A; gb = B;
    n = 0;
    while (!res_valid && n < 20) begin @(negedge clk); n++; end
    chk("result_wait", int'(n < 20), 1);
    gd = res_data; gr = res_rd; gc = res_carry; gz = res_zero;
  endtask

  initial begin
    logic [7:0] ga, gb, gd;
    logic [1:0] gr;
    logic       gc, gz;
    int         n;
    rst = 1'b1; instr_valid = 0; instr_op = 0; instr_rd = 0;
    instr_rs1 = 0; instr_rs2 = 0; instr_use_imm = 0; instr_imm = 0;
    res_ready = 1'b1; dbg_addr = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dbg_addr = i[1:0];
      #1 chk("dbg_after_reset", int'(dbg_data), 0);
    end
    @(negedge clk);

    issue(3'd3, 2'd1, 2'd0, 2'd0, 1'b1, 8'hF0, ga, gb, gd, gr, gc, gz);
    chk("load_r1", int'(gd), 8'hF0);
    chk("load_r1_c", int'(gc), 0);
    chk("load_r1_z", int'(gz), 0);
    issue(3'd3, 2'd2, 2'd0, 2'd0, 1'b1, 8'h20, ga, gb, gd, gr, gc, gz);
    chk("load_r2", int'(gd), 8'h20);
    dbg_addr = 2'd1;
    #1 chk("dbg_r1", int'(dbg_data), 8'hF0);

    issue(3'd0, 2'd3, 2'd1, 2'd2, 1'b0, 8'h00, ga, gb, gd, gr, gc, gz);
    chk("add_A", int'(ga), 8'hF0);
    chk("add_B", int'(gb), 8'h20);
    chk("add_data", int'(gd), 8'h10);
    chk("add_carry", int'(gc), 1);
    chk("add_zero", int'(gz), 0);
    @(negedge clk);
    dbg_addr = 2'd3;
    #1 chk("dbg_r3", int'(dbg_data), 8'h10);

    issue(3'd1, 2'd0, 2'd1, 2'd0, 1'b1, 8'hF0, ga, gb, gd, gr, gc, gz);
    chk("sub_data", int'(gd), 0);
    chk("sub_zero", int'(gz), 1);
    chk("sub_carry", int'(gc), 0);
    chk("sub_rd", int'(gr), 0);
    dbg_addr = 2'd0;
    #1 chk("dbg_r0", int'(dbg_data), 0);
    issue(3'd5, 2'd0, 2'd2, 2'd1, 1'b0, 8'h00, ga, gb, gd, gr, gc, gz);
    chk("slt_data", int'(gd), 1);
    issue(3'd7, 2'd0, 2'd1, 2'd2, 1'b0, 8'h00, ga, gb, gd, gr, gc, gz);
    chk("op7_data", int'(gd), 0);
    chk("op7_zero", int'(gz), 1);
    @(negedge clk);

    res_ready = 1'b0;
    issue(3'd2, 2'd0, 2'd1, 2'd2, 1'b0, 8'h00, ga, gb, gd, gr, gc, gz);
    chk("and_data", int'(gd), 8'h20);
    for (int i = 0; i < 5; i++) begin
      instr_valid = (i == 2);
      @(negedge clk);
      chk("bp_valid", int'(res_valid), 1);
      chk("bp_data", int'(res_data), 8'h20);
      chk("bp_ready", int'(instr_ready), 0);
    end
    instr_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", int'(res_valid), 0);
    chk("bp_release_ready", int'(instr_ready), 1);

    acc_q.delete();
    instr_op = 3'd0; instr_rd = 2'd3; instr_rs1 = 2'd3;
    instr_use_imm = 1'b1; instr_imm = 8'h01; instr_valid = 1'b1;
    n = 0;
    while (acc_q.size() < 4 && n < 40) begin @(negedge clk); n++; end
    instr_valid = 1'b0;
    chk("b2b_wait", int'(n < 40), 1);
    if (acc_q.size() == 4)
      for (int i = 1; i < 4; i++)
        chk("b2b_spacing", acc_q[i] - acc_q[i-1], 3);
    repeat (2) @(negedge clk);
    dbg_addr = 2'd3;
    #1 chk("b2b_r3", int'(dbg_data), 8'h14);

    instr_op = 3'd3; instr_rd = 2'd2; instr_rs1 = 2'd0;
    instr_use_imm = 1'b1; instr_imm = 8'h55; instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    instr_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dbg_addr = 2'd2;
    #1;
    chk("rst_mid_ready", int'(instr_ready), 1);
    chk("rst_mid_valid", int'(res_valid), 0);
    chk("rst_mid_r2", int'(dbg_data), 0);
    @(negedge clk);

    for (int i = 0; i < 800; i++) begin
      rst           = ($urandom_range(0, 63) == 0);
      instr_valid   = $urandom_range(0, 1);
      instr_op      = 3'($urandom_range(0, 7));
      instr_rd      = 2'($urandom_range(0, 3));
      instr_rs1     = 2'($urandom_range(0, 3));
      instr_rs2     = 2'($urandom_range(0, 3));
      instr_use_imm = $urandom_range(0, 1);
      instr_imm     = 8'($urandom);
      res_ready     = ($urandom_range(0, 3) != 0);
      dbg_addr      = 2'($urandom_range(0, 3));
      @(negedge clk);
    end
    rst = 1'b0; instr_valid = 1'b0; res_ready = 1'b1;
    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, limit 500000");
    $fatal(1);
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Issue/writeback controller that sits directly upstream and downstream of the 8-bit ALU (`alu_8bit`).
- Accepts one instruction per valid/ready handshake.
- Reads operands from an internal register file (r0 hardwired to zero).
- Drives the ALU's A/B/ALU_Sel inputs from registers and captures ALU_Out/CarryOut/Zero one cycle later.
- Writes the result back and presents it on a result valid/ready handshake.
- One instruction in flight at a time; no hazards.

Parameters:
REG_AW, 2, register-address width; register file has 2**REG_AW entries of 8 bits, r0 reads 0.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
instr_valid  input  1  instruction offered
instr_ready  output  1  controller can accept (high only in IDLE and rst low)
instr_op  input  3  ALU operation code, passed to ALU_Sel
instr_rd  input  REG_AW  destination register
instr_rs1  input  REG_AW  source for A
instr_rs2  input  REG_AW  source for B when instr_use_imm=0
instr_use_imm  input  1  B taken from instr_imm instead of rs2
instr_imm  input  8  immediate operand
A  output  8  ALU operand A (registered)
B  output  8  ALU operand B (registered)
ALU_Sel  output  3  ALU opcode (registered)
ALU_Out  input  8  ALU result
CarryOut  input  1  ALU carry
Zero  input  1  ALU zero flag
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
res_data  output  8  captured ALU_Out
res_rd  output  REG_AW  destination of captured result
res_carry  output  1  captured CarryOut
res_zero  output  1  captured Zero
dbg_addr  input  REG_AW  debug read address
dbg_data  output  8  combinational rf[dbg_addr]; 0 when dbg_addr=0

Behaviour:
Reset (sync, active-high): all of the following go to 0 on the first clock edge with rst=1:
- state=IDLE
- every register file entry
- A, B, ALU_Sel
- res_valid, res_data, res_rd, res_carry, res_zero

instr_ready is combinationally 0 whenever rst=1.

FSM states: IDLE, EXEC, DONE.

IDLE:
- instr_ready=1.
- On edge with instr_valid&instr_ready, load the following, then go to EXEC:
  - A ← rf[rs1]
  - B ← use_imm ? imm : rf[rs2]
  - ALU_Sel ← op
  - latch rd internally
- instr_valid low: stay in IDLE; A/B/ALU_Sel hold their last values.

EXEC (exactly one cycle, ALU settles combinationally):
- On the next edge, capture into res_*: ALU_Out, CarryOut, Zero, rd.
- Write rf[rd] ← ALU_Out unless rd=0; writes to r0 are discarded.
- Set res_valid=1 and go to DONE.

DONE:
- res_valid=1; res_* held stable.
- On edge with res_ready=1: clear res_valid and go to IDLE.
- res_ready=0: hold indefinitely.
- instr_valid is ignored outside IDLE.

Timing:
- Accept at edge k, writeback and res_valid rise at edge k+1.
- dbg_data reflects the new value from edge k+1.
- With res_ready tied high, res_valid is high for exactly one cycle and the next accept is possible at edge k+3.
- Sustained throughput: 1 instruction per 3 cycles.

Data rules:
- No arithmetic in this block. Flags are captured exactly as driven by the ALU:
  - carry meaningful only for op 000 (ALU drives 0 otherwise)
  - SLT (101) result is 0x00/0x01, unsigned compare
  - op 111 yields 0x00 with zero=1
- A constant is loaded into a register via op 011 (OR) with rs1=0, use_imm=1.
- Reads of a register written by the previous instruction return the new value, since writeback completes before the next accept.

Reset mid-operation: an in-flight instruction in EXEC or DONE is discarded with no register write, and the FSM returns to IDLE.

Test Plan:
1. Reset 2 cycles, then load r1 ← op011 rs1=0 imm=0xF0 rd=1 and r2 ← imm 0x20 rd=2 -> res_data 0xF0 then 0x20, carry 0, zero 0; dbg_addr=1 reads 0xF0; after reset all dbg reads 0x00.
2. ADD op000 rs1=1 rs2=2 rd=3 -> A=0xF0, B=0x20 one cycle after accept; res_data 0x10, res_carry 1, res_zero 0; rf[3]=0x10.
3. SUB op001 rs1=1 imm=0xF0 rd=0 -> res_data 0x00, res_zero 1, res_carry 0, res_rd 0; dbg r0 still 0x00. Then SLT op101 rs1=2 rs2=1 -> 0x01. Then op111 -> 0x00, zero 1.
4. Backpressure: res_ready low 5 cycles after res_valid rises -> res_valid and res_* stable, instr_ready 0, concurrent instr_valid pulse not accepted. res_ready high -> IDLE next cycle.
5. Back-to-back instr_valid held high with res_ready high -> accepts exactly every 3 cycles; a write to r3 followed by a read of r3 returns the updated value.
6. Assert rst for 1 cycle while in EXEC of a write to r2=0x55 -> no write (rf[2]=0x00), res_valid 0, state IDLE, instr_ready 1 the cycle after rst falls.
